jacobi_sweep_ctrl: RTL and testbench
====================================

Name: jacobi_sweep_ctrl

Overview:
- Owns the grid state register that feeds the combinational `jacobi` stage, and consumes its updated grid each clock.
- Loads an initial grid serially, runs a fixed number of Jacobi sweeps on command, then streams the result out serially.
- Replaces the bench-level feedback register (`u_Array <= u_Outs`) with a controlled, resettable, handshaked datapath.

Parameters:
- WIDTH, 8, bits per grid cell (unsigned)
- NU, 10, number of grid cells
- ITER_W, 16, width of the iteration limit and iteration counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- load_valid  in  1  load beat valid
- load_ready  out  1  load beat accepted when valid & ready
- load_data  in  WIDTH  cell value, cells written in index order 0..NU-1
- start  in  1  single-cycle request to begin sweeps
- max_iters  in  ITER_W  sweep count, sampled when start is accepted
- tol  in  WIDTH  convergence threshold (used only with JACOBI_CONVERGE_EN)
- u_state  out  WIDTH*NU  current grid, drives jacobi input; cell i at [i*WIDTH +: WIDTH]
- u_next  in  WIDTH*NU  jacobi output for u_state
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream ready
- out_data  out  WIDTH  result cell, index order 0..NU-1
- busy  out  1  high when state is not IDLE
- done  out  1  one-cycle pulse after the last result beat is accepted
- iter_count  out  ITER_W  sweeps performed in the last or current run
- converged  out  1  early-exit flag for the last run

Behaviour:
- Reset (rst_n=0 at a clock edge) forces:
  - u_state=0, state=IDLE, load index=0, out index=0, iter_count=0
  - out_valid=0, done=0, converged=0
  - load_ready=1 on the following cycle
- Reset takes priority in every state and aborts any run or readout; no done pulse is produced.
- States are IDLE, RUN and OUT.
- IDLE:
  - load_ready=1.
  - On each accepted beat: u_state cell[load index] <= load_data, and load index increments. After index NU-1 it wraps to 0.
  - Cells not loaded keep their prior value.
  - On start:
    - latch max_iters
    - clear iter_count and converged
    - reset load index to 0
    - go to RUN
    - if the latched value is 0, go directly to OUT instead
  - If start and an accepted load beat coincide, the beat is written first, then the start takes effect.
- RUN:
  - load_ready=0; start is ignored.
  - Every cycle: u_state <= u_next and iter_count increments.
  - After exactly max_iters RUN cycles, go to OUT. Latency from start is max_iters+1 cycles to the first out_valid.
- OUT:
  - out_valid=1, out_data = u_state cell[out index]; u_state is frozen.
  - On out_valid & out_ready, out index increments.
  - While out_ready=0, out_data is held stable.
  - When cell NU-1 is accepted: out index returns to 0, done pulses for 1 cycle, state returns to IDLE.
  - start and load beats are ignored in this state.
- iter_count holds its final value until the next accepted start or reset.
- Arithmetic: the counter wraps are not reachable because sweeps are bounded by the latched max_iters. No saturation is needed.

Optional Feature:
- Macro: JACOBI_CONVERGE_EN
- Defined:
  - In RUN, compute residual = max over i of |u_next[i] - u_state[i]| (unsigned, WIDTH bits).
  - If residual <= tol, that cycle's update is still applied and iter_count still increments.
  - Then converged <= 1 and the next state is OUT, even if fewer than max_iters sweeps have run.
  - The max_iters limit still applies.
- Undefined:
  - No residual logic is built and tol is ignored.
  - converged is tied to 0.
  - The run is always exactly max_iters sweeps.

Test Plan (NU=10, WIDTH=8; bench stub u_next = u_state + 1 per cell unless stated):
- Reset: hold rst_n=0 for 2 clocks -> u_state=0, load_ready=1, out_valid=0, done=0, busy=0, iter_count=0.
- Basic run: load 10..19, then start with max_iters=5 -> busy for 5 RUN cycles; readout 15,16,...,24; done pulses once; iter_count=5.
- Zero iterations: load 3,3,...,3, then start with max_iters=0 -> OUT the next cycle; readout all 3s; iter_count=0.
- Backpressure: basic run with out_ready toggling 1,0,0,1,... -> every value is held while ready=0; exactly 10 beats with no skip or duplicate; done only after beat 9.
- Reset mid-RUN: max_iters=100, assert rst_n=0 at sweep 40 -> next cycle u_state=0, state IDLE, no done, iter_count=0.
- Convergence (JACOBI_CONVERGE_EN, identity stub u_next=u_state, tol=0, max_iters=50) -> exit after 1 sweep; converged=1; iter_count=1; readout equals the loaded values.

Source files
------------

// File: rtl/jacobi_sweep_ctrl.sv
// jacobi_sweep_ctrl: grid state owner for a Jacobi stage - serial load, bounded sweeps, serial readout.
// Optional early exit on convergence is built when JACOBI_CONVERGE_EN is defined.
module jacobi_sweep_ctrl #(
    parameter int WIDTH  = 8,
    parameter int NU     = 10,
    parameter int ITER_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  start,
    input  logic [ITER_W-1:0]     max_iters,
    input  logic [WIDTH-1:0]      tol,
    output logic [WIDTH*NU-1:0]   u_state,
    input  logic [WIDTH*NU-1:0]   u_next,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_W-1:0]     iter_count,
    output logic                  converged
);
    localparam int IW = (NU > 1) ? $clog2(NU) : 1;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   cells [NU];
    logic [IW-1:0]      load_idx, out_idx;
    logic [ITER_W-1:0]  max_lat;
    logic               last_sweep, out_last, hit;

    for (genvar g = 0; g < NU; g++) begin : g_pack
        assign u_state[g*WIDTH +: WIDTH] = cells[g];
    end

    assign load_ready = (state == IDLE);
    assign out_valid  = (state == OUT);
    assign busy       = (state != IDLE);
    assign out_data   = cells[out_idx];
    assign last_sweep = (iter_count + ITER_W'(1)) == max_lat;
    assign out_last   = (out_idx == IW'(NU - 1));

`ifdef JACOBI_CONVERGE_EN
    logic [WIDTH-1:0] residual, diff;

    // Largest per-cell change produced by this sweep.
    always_comb begin
        residual = '0;
        diff     = '0;
        for (int i = 0; i < NU; i++) begin
            diff = (u_next[i*WIDTH +: WIDTH] > cells[i]) ? u_next[i*WIDTH +: WIDTH] - cells[i]
                                                          : cells[i] - u_next[i*WIDTH +: WIDTH];
            residual = (diff > residual) ? diff : residual;
        end
    end

    assign hit = (state == RUN) && (residual <= tol);

    // Converged flag: cleared by a new run, set when a sweep lands within tolerance.
    always_ff @(posedge clk) begin
        if (!rst_n)
            converged <= 1'b0;
        else if (state == IDLE && start)
            converged <= 1'b0;
        else if (hit)
            converged <= 1'b1;
    end
`else
    logic tol_unused;
    assign tol_unused = ^tol;
    assign hit        = 1'b0;
    assign converged  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state: zero-sweep runs skip straight to readout.
    always_comb begin
        state_nx = (state == IDLE) ? (start ? ((max_iters == '0) ? OUT : RUN) : IDLE) :
                   (state == RUN)  ? ((last_sweep || hit) ? OUT : RUN) :
                   (state == OUT)  ? ((out_ready && out_last) ? IDLE : OUT) : IDLE;
    end

    // Grid, indices, sweep counter and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NU; i++) cells[i] <= '0;
            load_idx   <= '0;
            out_idx    <= '0;
            iter_count <= '0;
            max_lat    <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        cells[load_idx] <= load_data;
                        load_idx        <= (load_idx == IW'(NU - 1)) ? '0 : load_idx + 1'b1;
                    end
                    if (start) begin
                        max_lat    <= max_iters;
                        iter_count <= '0;
                        load_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NU; i++) cells[i] <= u_next[i*WIDTH +: WIDTH];
                    iter_count <= iter_count + 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_idx <= out_last ? '0 : out_idx + 1'b1;
                        done    <= out_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// tb_jacobi_sweep_ctrl: randomized self-checking bench against a cell-array reference model.
module tb_jacobi_sweep_ctrl;
    localparam int WIDTH  = 8;
    localparam int NU     = 10;
    localparam int ITER_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_valid = 1'b0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [WIDTH-1:0]     load_data = '0;
    logic [WIDTH-1:0]     tol = '0;
    logic [ITER_W-1:0]    max_iters = '0;
    logic [WIDTH*NU-1:0]  u_state, u_next;
    logic                 load_ready, out_valid, busy, done, converged;
    logic [WIDTH-1:0]     out_data;
    logic [ITER_W-1:0]    iter_count;
    logic                 stub_id = 1'b0;
    logic [WIDTH-1:0]     ld [NU];
    int                   n_checks = 0;
    int                   n_fail = 0;

    jacobi_sweep_ctrl #(.WIDTH(WIDTH), .NU(NU), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .start(start), .max_iters(max_iters), .tol(tol),
        .u_state(u_state), .u_next(u_next), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .iter_count(iter_count),
        .converged(converged)
    );

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_stub
        assign u_next[g*WIDTH +: WIDTH] = u_state[g*WIDTH +: WIDTH] + (stub_id ? 8'd0 : 8'd1);
    end

    task automatic check(input string tag, input logic [WIDTH*NU-1:0] got, input logic [WIDTH*NU-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input bit combo, input int iters);
        for (int i = 0; i < NU; i++) begin
            load_valid = 1'b1;
            load_data  = ld[i];
            if (combo && i == NU - 1) begin
                start     = 1'b1;
                max_iters = ITER_W'(iters);
            end
            tick();
        end
        load_valid = 1'b0;
        if (!combo) begin
            start     = 1'b1;
            max_iters = ITER_W'(iters);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic do_run(input int iters, input int mode, input bit combo,
                          input int exp_lat, input int exp_it, input bit exp_conv);
        int lat, beat, cyc;
        logic rdy;
        logic [WIDTH-1:0] exp_v [NU];
        for (int i = 0; i < NU; i++) exp_v[i] = ld[i] + (stub_id ? 8'd0 : 8'(exp_it));
        load_all(combo, iters);
        check("busy_after_start", busy, 1);
        lat = 0;
        while (!out_valid && lat < 300) begin
            check("load_ready_run", load_ready, 0);
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            start      = 1'($urandom);
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        beat = 0;
        cyc  = 0;
        while (beat < NU && cyc < 200) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
            out_ready  = rdy;
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            start      = 1'($urandom);
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_v[beat]);
            check("done_early", done, 0);
            tick();
            cyc++;
            if (rdy) beat++;
        end
        out_ready  = 1'b0;
        load_valid = 1'b0;
        start      = 1'b0;
        check("done_pulse", done, 1);
        check("out_valid_end", out_valid, 0);
        check("busy_end", busy, 0);
        check("iter_count", iter_count, exp_it);
        check("converged", converged, exp_conv);
        tick();
        check("done_single", done, 0);
        check("iter_hold", iter_count, exp_it);
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_u_state", u_state, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_iter", iter_count, 0);
        check("rst_conv", converged, 0);
        check("rst_load_ready", load_ready, 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NU; i++) ld[i] = 8'(10 + i);
        do_run(5, 0, 1'b0, 5, 5, 1'b0);

        for (int i = 0; i < NU; i++) ld[i] = 8'd3;
        do_run(0, 0, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < NU; i++) ld[i] = 8'(10 + i);
        do_run(5, 1, 1'b0, 5, 5, 1'b0);

        for (int i = 0; i < NU; i++) ld[i] = 8'($urandom);
        load_all(1'b0, 100);
        for (int i = 0; i < 40; i++) tick();
        check("mid_busy", busy, 1);
        check("mid_iter", iter_count, 40);
        rst_n = 1'b0;
        tick();
        check("abort_u_state", u_state, 0);
        check("abort_busy", busy, 0);
        check("abort_iter", iter_count, 0);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        tick();
        check("abort_load_ready", load_ready, 1);
        check("abort_no_done", done, 0);

        for (int r = 0; r < 8; r++) begin
            int it;
            for (int i = 0; i < NU; i++) ld[i] = 8'($urandom);
            it = int'($urandom_range(0, 12));
            do_run(it, int'($urandom_range(0, 2)), 1'($urandom), it, it, 1'b0);
        end

`ifdef JACOBI_CONVERGE_EN
        stub_id = 1'b1;
        tol     = '0;
        for (int i = 0; i < NU; i++) ld[i] = 8'($urandom);
        do_run(50, 0, 1'b0, 1, 1, 1'b1);
        stub_id = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
